// File: rtl/rf_op_sequencer_if.sv
// Command, response and register-file port bundle for rf_op_sequencer.
// slave is the sequencer side; master is the command source / register-file owner side.
interface rf_op_sequencer_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] rf_raddr1;
    logic [AW-1:0] rf_raddr2;
    logic [DW-1:0] rf_rdata1;
    logic [DW-1:0] rf_rdata2;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_wen;
    logic          init_done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        input  rsp_ready, rf_rdata1, rf_rdata2,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wen, init_done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        output rsp_ready, rf_rdata1, rf_rdata2,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wen, init_done
    );
endinterface

// File: rtl/rf_op_sequencer.sv
// Clears an external register file after reset, then executes one two-operand
// command at a time (read, compute, write back) and returns a single response.
module rf_op_sequencer #(
    parameter int NREGS = 8,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_op_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {INIT, IDLE, READ, WRITE, RESP} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_MOV = 2'b11} op_t;

    localparam logic [AW:0]   NREGS_W   = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    state_t        state_q;
    op_t           op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] sweep_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;
    logic [AW-1:0] raddr1_q;
    logic [AW-1:0] raddr2_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          wen_q;
    logic          init_done_q;

    logic [DW-1:0] result_d;
    logic [AW-1:0] cmd_addr [3];
    logic [2:0]    addr_oor;

    assign cmd_addr[0] = bus.cmd_rd;
    assign cmd_addr[1] = bus.cmd_rs1;
    assign cmd_addr[2] = bus.cmd_rs2;

    // Zero-extend by one bit so NREGS == 2**AW never reports an error.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_addr_chk
            assign addr_oor[gi] = ({1'b0, cmd_addr[gi]} >= NREGS_W);
        end
    endgenerate

    always_comb begin
        result_d = bus.rf_rdata1;
        case (op_q)
            OP_ADD:  result_d = bus.rf_rdata1 + bus.rf_rdata2;
            OP_SUB:  result_d = bus.rf_rdata1 - bus.rf_rdata2;
            OP_AND:  result_d = bus.rf_rdata1 & bus.rf_rdata2;
            default: result_d = bus.rf_rdata1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            sweep_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    // wen_q marks that the entry in waddr_q is being written this cycle.
                    if (wen_q && waddr_q == LAST_ADDR) begin
                        wen_q       <= 1'b0;
                        waddr_q     <= '0;
                        init_done_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wen_q   <= 1'b1;
                        waddr_q <= sweep_q;
                        wdata_q <= '0;
                        sweep_q <= sweep_q + AW'(1);
                    end
                end
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= op_t'(bus.cmd_op);
                        rd_q        <= bus.cmd_rd;
                        if (|addr_oor) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            raddr1_q <= bus.cmd_rs1;
                            raddr2_q <= bus.cmd_rs2;
                            state_q  <= READ;
                        end
                    end
                end
                READ: begin
                    raddr1_q <= '0;
                    raddr2_q <= '0;
                    wen_q    <= 1'b1;
                    waddr_q  <= rd_q;
                    wdata_q  <= result_d;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    wen_q       <= 1'b0;
                    waddr_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= wdata_q;
                    rsp_err_q   <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rf_raddr1 = raddr1_q;
    assign bus.rf_raddr2 = raddr2_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.rf_wen    = wen_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: owns the register file, compares every command
// against a transaction-level model of the register contents.
module tb_rf_op_sequencer;
    localparam int NREGS = 8;
    localparam int AW    = 4;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rf_op_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    rf_op_sequencer #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] tb_rf [16];
    int            wr_cnt = 0;
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    int model_rf [NREGS];
    int n_checks = 0;
    int n_fail   = 0;

    assign bus.rf_rdata1 = tb_rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = tb_rf[bus.rf_raddr2];

    always @(posedge clk) begin
        if (bus.rf_wen === 1'b1) begin
            tb_rf[bus.rf_waddr] <= bus.rf_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (bd_en) begin
            tb_rf[bd_addr] <= bd_data;
        end
    end

    // Backdoor load of the external register file; called at a negedge.
    task automatic preload(input int addr, input int data);
        bd_en   = 1'b1;
        bd_addr = AW'(addr);
        bd_data = DW'(data);
        @(negedge clk);
        bd_en = 1'b0;
        if (addr < NREGS) model_rf[addr] = data % 65536;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_rd = '0;
        bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) preload(i, 16'hA5A0 + i);
        n_checks++;
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
            bus.rsp_err !== 1'b0 || bus.rf_wen !== 1'b0 || bus.rf_waddr !== '0 ||
            bus.rf_wdata !== '0 || bus.rf_raddr1 !== '0 || bus.rf_raddr2 !== '0 ||
            bus.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b vld=%b data=%h err=%b wen=%b wa=%h wd=%h ra1=%h ra2=%h done=%b, required all zero",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rf_wen,
                     bus.rf_waddr, bus.rf_wdata, bus.rf_raddr1, bus.rf_raddr2, bus.init_done);
        end
    endtask

    // Releases reset at the current negedge and checks the clear sweep.
    task automatic test_init_sweep;
        int idx = 0;
        int first_c = -1;
        bit rf_clear = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 3 * NREGS; c++) begin
            @(negedge clk);
            if (bus.rf_wen === 1'b1) begin
                if (first_c < 0) first_c = c;
                n_checks++;
                if (bus.rf_waddr !== AW'(idx) || bus.rf_wdata !== '0 || bus.init_done !== 1'b0 ||
                    bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_entry: idx=%0d waddr=%0d wdata=%h done=%b rdy=%b vld=%b, required waddr=%0d wdata=0 others 0",
                             idx, bus.rf_waddr, bus.rf_wdata, bus.init_done, bus.cmd_ready, bus.rsp_valid, idx);
                end
                idx++;
            end else if (idx > 0) begin
                break;
            end
        end
        n_checks++;
        if (idx != NREGS || first_c != 0) begin
            n_fail++;
            $display("FAIL sweep_length: wen cycles=%0d first at cycle %0d, required %0d starting at cycle 0",
                     idx, first_c, NREGS);
        end
        n_checks++;
        if (bus.init_done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_done: init_done=%b cmd_ready=%b, required 1 1", bus.init_done, bus.cmd_ready);
        end
        for (int i = 0; i < NREGS; i++) if (tb_rf[i] !== '0) rf_clear = 1'b0;
        n_checks++;
        if (!rf_clear) begin
            n_fail++;
            $display("FAIL sweep_clear: register file not all zero after sweep, required all zero");
        end
        for (int i = 0; i < NREGS; i++) model_rf[i] = 0;
        $display("txn sweep entries=%0d init_done=%b", idx, bus.init_done);
    endtask

    // One complete command with response hold of 'hold' cycles; called at a negedge.
    task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2, input int hold);
        bit            exp_err;
        int            a, b, r;
        logic [DW-1:0] exp_data;
        int            exp_lat, lat, wr0, waited;
        exp_err = (rd >= NREGS) || (rs1 >= NREGS) || (rs2 >= NREGS);
        r = 0;
        if (!exp_err) begin
            a = model_rf[rs1];
            b = model_rf[rs2];
            case (op)
                0:       r = (a + b) % 65536;
                1:       r = (a - b + 65536) % 65536;
                2:       r = a & b;
                default: r = a;
            endcase
        end
        exp_data = DW'(r);
        exp_lat  = exp_err ? 1 : 3;
        bus.rsp_ready = (hold == 0);
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, waited);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_rd    = AW'(rd);
        bus.cmd_rs1   = AW'(rs1);
        bus.cmd_rs2   = AW'(rs2);
        wr0 = wr_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin
            if (!exp_err && lat == 1) begin
                n_checks++;
                if (bus.rf_raddr1 !== AW'(rs1) || bus.rf_raddr2 !== AW'(rs2) || bus.rf_wen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_addr: ra1=%0d ra2=%0d wen=%b, required %0d %0d 0",
                             bus.rf_raddr1, bus.rf_raddr2, bus.rf_wen, rs1, rs2);
                end
            end
            if (!exp_err && lat == 2) begin
                n_checks++;
                if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== AW'(rd) || bus.rf_wdata !== exp_data ||
                    bus.rf_raddr1 !== '0 || bus.rf_raddr2 !== '0) begin
                    n_fail++;
                    $display("FAIL write_port: wen=%b waddr=%0d wdata=%h ra1=%0d ra2=%0d, required 1 %0d %h 0 0",
                             bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.rf_raddr1, bus.rf_raddr2, rd, exp_data);
                end
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL rsp_latency: rsp_valid=%b after %0d cycles, required 1 after %0d", bus.rsp_valid, lat, exp_lat);
        end
        n_checks++;
        if (bus.rsp_data !== exp_data || bus.rsp_err !== exp_err || bus.cmd_ready !== 1'b0 ||
            bus.rf_wen !== 1'b0 || bus.rf_raddr1 !== '0 || bus.rf_raddr2 !== '0) begin
            n_fail++;
            $display("FAIL rsp_value: data=%h err=%b rdy=%b wen=%b ra1=%0d ra2=%0d, required %h %b 0 0 0 0",
                     bus.rsp_data, bus.rsp_err, bus.cmd_ready, bus.rf_wen, bus.rf_raddr1, bus.rf_raddr2,
                     exp_data, exp_err);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.rsp_err !== exp_err ||
                bus.cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_hold: cycle %0d vld=%b data=%h err=%b rdy=%b, required 1 %h %b 0",
                         h, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready, exp_data, exp_err);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b, required 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        n_checks++;
        if (wr_cnt - wr0 != (exp_err ? 0 : 1)) begin
            n_fail++;
            $display("FAIL write_count: %0d writes, required %0d", wr_cnt - wr0, exp_err ? 0 : 1);
        end
        if (!exp_err) begin
            model_rf[rd] = r;
            n_checks++;
            if (tb_rf[rd] !== exp_data) begin
                n_fail++;
                $display("FAIL rf_contents: r%0d=%h, required %h", rd, tb_rf[rd], exp_data);
            end
        end
        $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d hold=%0d -> data=%h err=%b lat=%0d",
                 op, rd, rs1, rs2, hold, exp_data, exp_err, lat);
    endtask

    task automatic test_arith;
        preload(1, 16'hFFFF);
        preload(2, 16'h0002);
        run_cmd(0, 3, 1, 2, 0);
        n_checks++;
        if (tb_rf[3] !== 16'h0001) begin
            n_fail++;
            $display("FAIL add_wrap: r3=%h, required 0001", tb_rf[3]);
        end
        run_cmd(1, 4, 2, 1, 0);
        n_checks++;
        if (tb_rf[4] !== 16'h0003) begin
            n_fail++;
            $display("FAIL sub_wrap: r4=%h, required 0003", tb_rf[4]);
        end
        run_cmd(2, 5, 1, 4, 0);
        run_cmd(3, 6, 1, 0, 0);
        run_cmd(0, 1, 1, 2, 0);
    endtask

    task automatic test_error;
        run_cmd(0, 5, 1, 9, 0);
        run_cmd(3, 8, 1, 2, 0);
        run_cmd(1, 2, 15, 0, 2);
    endtask

    task automatic test_backpressure;
        run_cmd(2, 7, 4, 6, 5);
    endtask

    task automatic test_reset_in_write;
        int w0;
        preload(1, 16'h0005);
        preload(2, 16'h0007);
        preload(3, 16'h1234);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_rd    = AW'(3);
        bus.cmd_rs1   = AW'(1);
        bus.cmd_rs2   = AW'(2);
        w0 = wr_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rf_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL write_phase: rf_wen=%b, required 1", bus.rf_wen);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rf_wen !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: wen=%b vld=%b rdy=%b done=%b, required 0 0 0 0",
                     bus.rf_wen, bus.rsp_valid, bus.cmd_ready, bus.init_done);
        end
        @(negedge clk);
        n_checks++;
        if (wr_cnt != w0 || tb_rf[3] !== 16'h1234) begin
            n_fail++;
            $display("FAIL abandoned_write: writes=%0d r3=%h, required 0 1234", wr_cnt - w0, tb_rf[3]);
        end
        $display("txn reset during WRITE");
        repeat (2) @(negedge clk);
        test_init_sweep();
    endtask

    task automatic test_random;
        int op, rd, rs1, rs2, hold;
        for (int i = 0; i < NREGS; i++) preload(i, int'($urandom_range(0, 65535)));
        for (int n = 0; n < 30; n++) begin
            op   = int'($urandom_range(0, 3));
            rd   = ($urandom_range(0, 11) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            rs1  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            rs2  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            run_cmd(op, rd, rs1, rs2, hold);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_sweep();
        test_arith();
        test_error();
        test_backpressure();
        test_reset_in_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
